// File: rtl/corr_multi_rect.sv
// N-channel rectangular-window correlator streaming normalised counts as byte packets.
// Optional macro CORR_MULTI_RECT_CHECKSUM_EN appends an XOR checksum byte to each packet.
module corr_multi_rect #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned TIME_W = 16,
  parameter int unsigned EXP_W  = $clog2(TIME_W + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_strobe,
  input  logic             i_enable,
  input  logic [EXP_W-1:0] i_windowLengthExp,
  input  logic [N_CH-1:0]  i_x,
  input  logic             i_y,
  output logic [7:0]       o_bp_data,
  output logic             o_bp_valid,
  input  logic             i_bp_ready,
  output logic [7:0]       o_winNum,
  output logic [7:0]       o_dropCount,
  output logic             o_busy
);

  localparam int unsigned CNT_W = TIME_W + 1;
  localparam int unsigned NRM_W = TIME_W + 9;
`ifdef CORR_MULTI_RECT_CHECKSUM_EN
  localparam int unsigned PKT_L = 3 + 3 * N_CH;
`else
  localparam int unsigned PKT_L = 2 + 3 * N_CH;
`endif
  localparam int unsigned IDX_W = $clog2(PKT_L);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [CNT_W-1:0] cnt_y_q, cnt_y_d, cnt_y_n;
  logic [CNT_W-1:0] cnt_x_q [N_CH];
  logic [CNT_W-1:0] cnt_x_d [N_CH];
  logic [CNT_W-1:0] cnt_x_n [N_CH];
  logic [CNT_W-1:0] cnt_i_q [N_CH];
  logic [CNT_W-1:0] cnt_i_d [N_CH];
  logic [CNT_W-1:0] cnt_i_n [N_CH];
  logic [CNT_W-1:0] cnt_s_q [N_CH];
  logic [CNT_W-1:0] cnt_s_d [N_CH];
  logic [CNT_W-1:0] cnt_s_n [N_CH];
  logic [7:0]       win_q, win_d;
  logic [7:0]       drop_q, drop_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       snap_q [PKT_L];
  logic [7:0]       snap_d [PKT_L];
  logic [7:0]       snap_n [PKT_L];

  logic             sample, wrap, hs, last_hs;
  logic [CNT_W-1:0] mask;

  // count/2^e scaled to 256, saturated to one byte
  function automatic logic [7:0] norm(input logic [CNT_W-1:0] cnt, input logic [EXP_W-1:0] e);
    logic [NRM_W-1:0] s;
    s = (NRM_W'(cnt) << 8) >> e;
    return (s > NRM_W'(255)) ? 8'hFF : s[7:0];
  endfunction

  always_comb begin
    sample  = i_cg && i_strobe && i_enable;
    mask    = (CNT_W'(1) << i_windowLengthExp) - CNT_W'(1);
    wrap    = sample && ((t_q & mask) == mask);
    hs      = i_cg && (state_q == S_SEND) && i_bp_ready;
    last_hs = hs && (idx_q == IDX_W'(PKT_L - 1));

    // Counts including the current sample, so a wrapping sample lands in the snapshot
    cnt_y_n = cnt_y_q + CNT_W'(i_y);
    for (int unsigned c = 0; c < N_CH; c++) begin
      cnt_x_n[c] = cnt_x_q[c] + CNT_W'(i_x[c]);
      cnt_i_n[c] = cnt_i_q[c] + CNT_W'(i_x[c] & i_y);
      cnt_s_n[c] = cnt_s_q[c] + CNT_W'(i_x[c] ^ i_y);
    end

    snap_n[0] = win_q;
    snap_n[1] = norm(cnt_y_n, i_windowLengthExp);
    for (int unsigned c = 0; c < N_CH; c++) begin
      snap_n[2 + 3 * c] = norm(cnt_x_n[c], i_windowLengthExp);
      snap_n[3 + 3 * c] = norm(cnt_i_n[c], i_windowLengthExp);
      snap_n[4 + 3 * c] = norm(cnt_s_n[c], i_windowLengthExp);
    end
`ifdef CORR_MULTI_RECT_CHECKSUM_EN
    snap_n[PKT_L-1] = 8'h00;
    for (int unsigned b = 0; b < PKT_L - 1; b++) snap_n[PKT_L-1] = snap_n[PKT_L-1] ^ snap_n[b];
`endif

    state_d = state_q;
    t_d     = t_q;
    cnt_y_d = cnt_y_q;
    cnt_x_d = cnt_x_q;
    cnt_i_d = cnt_i_q;
    cnt_s_d = cnt_s_q;
    win_d   = win_q;
    drop_d  = drop_q;
    idx_d   = idx_q;
    snap_d  = snap_q;

    if (i_cg) begin
      if (!i_enable || wrap) begin
        t_d     = '0;
        cnt_y_d = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
          cnt_x_d[c] = '0;
          cnt_i_d[c] = '0;
          cnt_s_d[c] = '0;
        end
      end else if (sample) begin
        t_d     = t_q + CNT_W'(1);
        cnt_y_d = cnt_y_n;
        cnt_x_d = cnt_x_n;
        cnt_i_d = cnt_i_n;
        cnt_s_d = cnt_s_n;
      end

      // Snapshot shifts toward byte 0 so o_bp_data comes straight from a flop
      if (hs) begin
        for (int unsigned b = 0; b < PKT_L - 1; b++) snap_d[b] = snap_q[b + 1];
        snap_d[PKT_L-1] = 8'h00;
        idx_d = idx_q + IDX_W'(1);
        if (last_hs) state_d = S_IDLE;
      end

      if (wrap) begin
        win_d = win_q + 8'd1;
        if ((state_q == S_IDLE) || last_hs) begin
          snap_d  = snap_n;
          idx_d   = '0;
          state_d = S_SEND;
        end else if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      cnt_y_q <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        cnt_x_q[c] <= '0;
        cnt_i_q[c] <= '0;
        cnt_s_q[c] <= '0;
      end
      win_q  <= 8'h00;
      drop_q <= 8'h00;
      idx_q  <= '0;
      for (int unsigned b = 0; b < PKT_L; b++) snap_q[b] <= 8'h00;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_y_q <= cnt_y_d;
      cnt_x_q <= cnt_x_d;
      cnt_i_q <= cnt_i_d;
      cnt_s_q <= cnt_s_d;
      win_q   <= win_d;
      drop_q  <= drop_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign o_bp_data   = snap_q[0];
  assign o_bp_valid  = (state_q == S_SEND);
  assign o_busy      = (state_q == S_SEND);
  assign o_winNum    = win_q;
  assign o_dropCount = drop_q;

endmodule

// File: tb/tb_corr_multi_rect.sv
// Randomised bench for corr_multi_rect against a sample-queue reference model.
module tb_corr_multi_rect;

  localparam int NCH = 3;
  localparam int TW  = 16;
  localparam int EW  = $clog2(TW + 1);
`ifdef CORR_MULTI_RECT_CHECKSUM_EN
  localparam int L = 3 + 3 * NCH;
`else
  localparam int L = 2 + 3 * NCH;
`endif

  logic           clk = 1'b0;
  logic           i_rst, i_cg, i_strobe, i_enable, i_y, i_bp_ready;
  logic [EW-1:0]  i_e;
  logic [NCH-1:0] i_x;
  logic [7:0]     o_bp_data, o_winNum, o_dropCount;
  logic           o_bp_valid, o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: samples of the open window and bytes still to be delivered
  logic [NCH-1:0] xs[$];
  logic           ys[$];
  logic [7:0]     pkt_q[$];
  int             win_m, drop_m;

  corr_multi_rect #(.N_CH(NCH), .TIME_W(TW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_cg(i_cg), .i_strobe(i_strobe), .i_enable(i_enable),
    .i_windowLengthExp(i_e), .i_x(i_x), .i_y(i_y), .o_bp_data(o_bp_data),
    .o_bp_valid(o_bp_valid), .i_bp_ready(i_bp_ready), .o_winNum(o_winNum),
    .o_dropCount(o_dropCount), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int norm_m(input int cnt, input int e);
    int v;
    v = (cnt * 256) / (1 << e);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    xs.delete(); ys.delete(); pkt_q.delete();
    win_m = 0; drop_m = 0;
  endtask

  task automatic build_packet(output logic [7:0] b[$]);
    int cy;
    int cx[NCH], ci[NCH], cs[NCH];
    logic [7:0] ck;
    cy = 0;
    for (int c = 0; c < NCH; c++) begin cx[c] = 0; ci[c] = 0; cs[c] = 0; end
    for (int j = 0; j < xs.size(); j++) begin
      cy += int'(ys[j]);
      for (int c = 0; c < NCH; c++) begin
        cx[c] += int'(xs[j][c]);
        ci[c] += int'(xs[j][c] & ys[j]);
        cs[c] += int'(xs[j][c] ^ ys[j]);
      end
    end
    b.delete();
    b.push_back(8'(win_m));
    b.push_back(8'(norm_m(cy, int'(i_e))));
    for (int c = 0; c < NCH; c++) begin
      b.push_back(8'(norm_m(cx[c], int'(i_e))));
      b.push_back(8'(norm_m(ci[c], int'(i_e))));
      b.push_back(8'(norm_m(cs[c], int'(i_e))));
    end
`ifdef CORR_MULTI_RECT_CHECKSUM_EN
    ck = 8'h00;
    foreach (b[k]) ck ^= b[k];
    b.push_back(ck);
`else
    ck = 8'h00;
`endif
  endtask

  // Advance the reference across one rising edge using the inputs now driven
  task automatic model_clock();
    logic [7:0] b[$];
    if (!i_cg) return;
    if (pkt_q.size() > 0 && i_bp_ready) void'(pkt_q.pop_front());
    if (!i_enable) begin
      xs.delete(); ys.delete();
    end else if (i_strobe) begin
      xs.push_back(i_x);
      ys.push_back(i_y);
      if (xs.size() == (1 << int'(i_e))) begin
        build_packet(b);
        xs.delete(); ys.delete();
        if (pkt_q.size() == 0) pkt_q = b;
        else if (drop_m < 255) drop_m++;
        win_m = (win_m + 1) % 256;
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(o_bp_valid), 32'(pkt_q.size() > 0));
    chk("busy", 32'(o_busy), 32'(pkt_q.size() > 0));
    chk("winNum", 32'(o_winNum), 32'(win_m));
    chk("dropCount", 32'(o_dropCount), 32'(drop_m));
    if (pkt_q.size() > 0) chk($sformatf("data[%0d]", L - pkt_q.size()), 32'(o_bp_data), 32'(pkt_q[0]));
  endtask

  task automatic step();
    check_outputs();
    model_clock();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    i_strobe = 1'b0; i_bp_ready = 1'b1; i_cg = 1'b1;
    repeat (n) step();
  endtask

  task automatic restart(input int e);
    i_cg = 1'b1; i_enable = 1'b0; i_strobe = 1'b0;
    step();
    i_e = EW'(e); i_enable = 1'b1;
  endtask

  task automatic run_rand(input int cycles, input int p_strobe, input int p_ready, input int p_cg, input int p_en);
    for (int i = 0; i < cycles; i++) begin
      i_strobe   = ($urandom_range(0, 99) < p_strobe);
      i_bp_ready = ($urandom_range(0, 99) < p_ready);
      i_cg       = ($urandom_range(0, 99) < p_cg);
      i_enable   = ($urandom_range(0, 99) < p_en);
      i_x        = NCH'($urandom);
      i_y        = 1'($urandom);
      step();
    end
    i_enable = 1'b1;
  endtask

  initial begin
    i_rst = 1'b1; i_cg = 1'b1; i_strobe = 1'b0; i_enable = 1'b1; i_e = '0;
    i_x = '0; i_y = 1'b0; i_bp_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    chk("reset_data", 32'(o_bp_data), 32'h0);
    step();

    // Periodic strobe, e=2, always ready
    restart(2);
    for (int i = 0; i < 160; i++) begin
      i_strobe = (i % 4 == 3); i_x = NCH'($urandom); i_y = 1'($urandom);
      step();
    end
    drain(20);

    // Single-sample windows, constant inputs
    restart(0);
    i_x = NCH'(1); i_y = 1'b1;
    for (int i = 0; i < 100; i++) begin
      i_strobe = (i % 16 == 0);
      step();
    end
    drain(20);

    // Stalled consumer across three wraps, then release
    i_bp_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      i_strobe = (i % 4 == 0); i_x = NCH'($urandom); i_y = 1'($urandom);
      step();
    end
    i_strobe = 1'b0;
    chk("stall_drop_delta", 32'(o_dropCount), 32'(drop_m));
    drain(40);

    // Wrap coincides with final handshake: back-to-back packets
    for (int i = 0; i < 6 * L; i++) begin
      i_strobe = (i % L == 0); i_x = NCH'($urandom); i_y = 1'($urandom);
      step();
    end
    drain(20);

    // Reset while a packet is in flight
    i_strobe = 1'b1; step(); i_strobe = 1'b0;
    for (int k = 0; k < 40 && pkt_q.size() != L - 3; k++) step();
    if (pkt_q.size() != L - 3) chk("rst_wait_timeout", 32'(pkt_q.size()), 32'(L - 3));
    i_rst = 1'b1;
    #1;
    chk("rst_valid", 32'(o_bp_valid), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_win", 32'(o_winNum), 32'h0);
    model_reset();
    @(negedge clk);
    i_rst = 1'b0;
    restart(1);
    run_rand(60, 50, 100, 100, 100);
    drain(20);

    // Random stress with clock gating, enable drops and back-pressure
    for (int s = 0; s < 8; s++) begin
      restart($urandom_range(0, 3));
      run_rand(250, 60, 70, 85, 97);
    end
    drain(20);

    // Longer window
    restart(6);
    run_rand(300, 100, 50, 100, 100);
    drain(20);

    // Drop counter saturation and winNum wrap
    restart(0);
    i_bp_ready = 1'b0; i_strobe = 1'b1;
    for (int i = 0; i < 300; i++) begin
      i_x = NCH'($urandom); i_y = 1'($urandom);
      step();
    end
    i_strobe = 1'b0;
    chk("drop_saturated", 32'(o_dropCount), 32'd255);
    drain(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
